// File: rtl/store_buffer.sv
// store_buffer: posted-store FIFO that drains to a single memory port,
// sharing that port with loads and forwarding loads that hit a buffered store.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     st_ready,
  input  logic                     ld_req,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_ready,
  output logic [DW-1:0]            ld_data,
  output logic [AW-1:0]            mem_A,
  output logic [DW-1:0]            mem_WD,
  output logic                     mem_WE,
  input  logic [DW-1:0]            mem_RD,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0]   r_count;
  logic          w_run, w_full, w_empty, w_hit, w_load, w_drain, w_push;
  logic [DW-1:0] w_fwd;
  assign w_run   = !rst_n;
  assign w_full  = r_count == (PW+1)'(DEPTH);
  assign w_empty = r_count == '0;
  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    for (int i = 0; i < DEPTH; i++)
      if ((PW+1)'(i) < r_count && r_addr[r_head + PW'(i)] == ld_addr) begin
        w_hit = 1'b1;
        w_fwd = r_data[r_head + PW'(i)];
      end
  end
  assign w_load   = w_run && ld_req && !w_hit && !w_full;
  assign w_drain  = w_run && !w_empty && !w_load;
  assign w_push   = st_valid && st_ready;
  assign st_ready = w_run && !w_full;
  assign ld_ready = w_run && ld_req && (w_hit || !w_full);
  assign ld_data  = w_hit ? w_fwd : mem_RD;
  assign mem_A    = w_drain ? r_addr[r_head] : ld_addr;
  assign mem_WD   = w_drain ? r_data[r_head] : '0;
  assign mem_WE   = w_drain;
  assign count    = r_count;
  assign empty    = w_empty;
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_drain) r_head <= r_head + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_drain);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: queue-based reference model plus directed and random stimulus
// for the store buffer, with a small memory attached to its port.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  logic clk = 0;
  logic rst_n = 1;
  logic st_valid = 0, ld_req = 0;
  logic [AW-1:0] st_addr = '0, ld_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic st_ready, ld_ready, mem_WE, empty;
  logic [DW-1:0] ld_data, mem_WD, mem_RD;
  logic [AW-1:0] mem_A;
  logic [$clog2(DEPTH):0] count;
  int n_cmp = 0, n_err = 0;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t q[$];
  logic [DW-1:0] mem [512];
  logic [DW-1:0] ref_mem [512];
  logic m_drain, m_st_ready;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_ready(ld_ready), .ld_data(ld_data),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_WE) mem[mem_A[8:0]] <= mem_WD;
  assign mem_RD = mem[mem_A[8:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    int n;
    logic hit;
    logic [DW-1:0] fwd;
    logic grant;
    n = q.size();
    if (rst_n) begin
      m_drain = 0;
      m_st_ready = 0;
      chk("rst_st_ready", st_ready, 0);
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_mem_WE", mem_WE, 0);
    end else begin
      hit = 0;
      fwd = '0;
      foreach (q[i]) if (q[i].a == ld_addr) begin hit = 1; fwd = q[i].d; end
      grant = ld_req && !hit && n < DEPTH;
      m_drain = n > 0 && !grant;
      m_st_ready = n < DEPTH;
      chk("st_ready", st_ready, m_st_ready);
      chk("ld_ready", ld_ready, ld_req && (hit || n < DEPTH));
      if (ld_req && (hit || n < DEPTH)) chk("ld_data", ld_data, hit ? fwd : ref_mem[ld_addr[8:0]]);
      chk("mem_WE", mem_WE, m_drain);
      chk("mem_A", mem_A, m_drain ? q[0].a : ld_addr);
      chk("mem_WD", mem_WD, m_drain ? q[0].d : '0);
      chk("count", count, n);
      chk("empty", empty, n == 0);
    end
  end

  always @(posedge clk) begin
    if (rst_n) q.delete();
    else begin
      if (m_drain) begin
        ref_mem[q[0].a[8:0]] <= q[0].d;
        void'(q.pop_front());
      end
      if (st_valid && m_st_ready) q.push_back('{st_addr, st_data});
    end
  end

  task automatic drive(input logic r, input logic sv, input logic [AW-1:0] sa,
                       input logic [DW-1:0] sd, input logic lr, input logic [AW-1:0] la);
    @(posedge clk);
    #1;
    rst_n = r; st_valid = sv; st_addr = sa; st_data = sd; ld_req = lr; ld_addr = la;
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i] = 32'hDEAD0000 | i;
      ref_mem[i] = 32'hDEAD0000 | i;
    end
    drive(1, 1, 'h4, 'h1, 1, 'h4);
    chk("reset_st_ready", st_ready, 0);
    chk("reset_mem_WE", mem_WE, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("after_reset_count", count, 0);
    chk("after_reset_empty", empty, 1);
    // three back-to-back stores drain one cycle behind
    drive(0, 1, 'h4, 'h11, 0, 0);
    drive(0, 1, 'h8, 'h22, 0, 0);
    chk("t1_we1", mem_WE, 1); chk("t1_a1", mem_A, 'h4); chk("t1_wd1", mem_WD, 'h11);
    drive(0, 1, 'hC, 'h33, 0, 0);
    chk("t1_a2", mem_A, 'h8); chk("t1_wd2", mem_WD, 'h22);
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_we3", mem_WE, 1); chk("t1_a3", mem_A, 'hC); chk("t1_wd3", mem_WD, 'h33);
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_empty", empty, 1); chk("t1_we_off", mem_WE, 0);
    // missing load holds the port while the buffer fills
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 'h20 + 4 * k, 'h100 + k, 1, 'h100);
      chk("t2_ld_ready_fill", ld_ready, 1);
    end
    drive(0, 0, 0, 0, 1, 'h100);
    chk("t2_count_full", count, 4); chk("t2_st_ready", st_ready, 0);
    chk("t2_stall", ld_ready, 0); chk("t2_drain_we", mem_WE, 1); chk("t2_drain_a", mem_A, 'h20);
    drive(0, 0, 0, 0, 1, 'h100);
    chk("t2_ld_ready", ld_ready, 1); chk("t2_ld_a", mem_A, 'h100);
    chk("t2_count3", count, 3); chk("t2_ld_data", ld_data, 32'hDEAD0100);
    idle(4);
    // youngest of two matching entries is forwarded while the older drains
    drive(0, 1, 'h10, 'hAAAA, 1, 'h100);
    drive(0, 1, 'h10, 'hBBBB, 1, 'h100);
    drive(0, 0, 0, 0, 1, 'h10);
    chk("t3_ld_ready", ld_ready, 1); chk("t3_ld_data", ld_data, 'hBBBB);
    chk("t3_we", mem_WE, 1); chk("t3_a", mem_A, 'h10); chk("t3_wd", mem_WD, 'hAAAA);
    idle(3);
    // push and drain together keep count steady
    drive(0, 1, 'h30, 'h1, 1, 'h100);
    drive(0, 1, 'h34, 'h2, 1, 'h100);
    drive(0, 1, 'h38, 'h3, 0, 0);
    chk("t4_count", count, 2); chk("t4_a1", mem_A, 'h30);
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_count_same", count, 2); chk("t4_a2", mem_A, 'h34);
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_a3", mem_A, 'h38); chk("t4_wd3", mem_WD, 'h3);
    idle(2);
    // a store pushed this cycle is invisible to a same-cycle load
    drive(0, 1, 'h40, 'h5555, 1, 'h40);
    chk("t5_ld_ready", ld_ready, 1); chk("t5_old", ld_data, 32'hDEAD0040);
    idle(2);
    drive(0, 0, 0, 0, 1, 'h40);
    chk("t5_new", ld_data, 'h5555);
    // reset discards buffered stores
    drive(0, 1, 'h50, 'h7, 1, 'h100);
    drive(0, 1, 'h54, 'h8, 1, 'h100);
    drive(0, 1, 'h58, 'h9, 1, 'h100);
    drive(1, 0, 0, 0, 0, 0);
    chk("t6_count3", count, 3); chk("t6_we", mem_WE, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("t6_count0", count, 0); chk("t6_empty", empty, 1); chk("t6_no_we", mem_WE, 0);
    idle(3);
    drive(0, 0, 0, 0, 1, 'h50);
    chk("t6_discarded", ld_data, 32'hDEAD0050);
    for (int c = 0; c < 1500; c++)
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 15) << 2,
            $urandom, $urandom_range(0, 1), $urandom_range(0, 15) << 2);
    idle(8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
